// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types and constants for the sequenced binary32 multiplier
package fp_mul_pkg;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam int EXP_BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;
  typedef enum logic [2:0] {IDLE, MUL, NORM, RND, DONE} state_t;
  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: splits a binary32 into sign, exponent, hidden-bit mantissa (denormals flushed) and class
module fp_unpack
  import fp_mul_pkg::*;
(
  input  logic [EXP_W+MANT_W:0] x,
  output logic                  sign,
  output logic [EXP_W-1:0]      exp,
  output logic [MANT_W:0]       mant,
  output fp_class_t             cls
);
  logic [MANT_W-1:0] frac;
  assign sign = x[EXP_W+MANT_W];
  assign exp = x[EXP_W+MANT_W-1:MANT_W];
  assign frac = x[MANT_W-1:0];
  assign mant = exp != '0 ? {1'b1, frac} : '0;
  assign cls = '{zero: exp == '0, inf: &exp && ~|frac, nan: &exp && |frac};
endmodule

// File: rtl/mul_24bit.sv
// mul_24bit: combinational 24x24 mantissa multiplier
module mul_24bit (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] p
);
  assign p = a * b;
endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// fp_mul_seq_ctrl: handshaked multi-cycle binary32 multiplier around mul_24bit
// Define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even (adds an RND cycle); default truncates.
module fp_mul_seq_ctrl
  import fp_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inv,
  output logic        busy
);
  state_t state, nxt;
  logic [31:0] ra, rb;
  logic sa, sb, sign;
  logic [EXP_W-1:0] ea, eb;
  logic [MANT_W:0] ma, mb;
  fp_class_t cla, clb, ca, cb;
  logic [47:0] prod, p;
  logic signed [9:0] e, n_e, f_e;
  logic [MANT_W-1:0] n_mant, f_mant;
  logic [31:0] r_y;
  logic [2:0] r_f, flags;
  fp_unpack u_ua (.x(ra), .sign(sa), .exp(ea), .mant(ma), .cls(cla));
  fp_unpack u_ub (.x(rb), .sign(sb), .exp(eb), .mant(mb), .cls(clb));
  mul_24bit u_mul (.a(ma), .b(mb), .p(prod));
  assign n_mant = p[47] ? p[46:24] : p[45:23];
  assign n_e = p[47] ? e + 10'sd1 : e;
`ifdef FP_MUL_ROUND_NEAREST_EN
  logic [MANT_W-1:0] mant;
  logic guard, sticky, rnd_up, carry;
  assign rnd_up = guard && (sticky || mant[0]);
  assign {carry, f_mant} = {1'b0, mant} + {{MANT_W{1'b0}}, rnd_up};
  assign f_e = e + $signed({9'b0, carry});
`else
  logic unused_lsb;
  assign unused_lsb = ^p[22:0];
  assign f_mant = n_mant;
  assign f_e = n_e;
`endif
  always_comb begin
    r_y = {sign, f_e[EXP_W-1:0], f_mant};
    r_f = 3'b000;
    if (ca.nan || cb.nan || (ca.inf && cb.zero) || (ca.zero && cb.inf)) begin
      r_y = QNAN;
      r_f = 3'b001;
    end else if (ca.inf || cb.inf) r_y = {sign, POS_INF[30:0]};
    else if (ca.zero || cb.zero) r_y = {sign, ZERO[30:0]};
    else if (f_e >= 10'sd255) begin
      r_y = {sign, POS_INF[30:0]};
      r_f = 3'b100;
    end else if (f_e <= 10'sd0) begin
      r_y = {sign, ZERO[30:0]};
      r_f = 3'b010;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = in_valid ? MUL : IDLE;
      MUL: nxt = NORM;
`ifdef FP_MUL_ROUND_NEAREST_EN
      NORM: nxt = RND;
`else
      NORM: nxt = DONE;
`endif
      RND: nxt = DONE;
      DONE: nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      p <= '0;
      sign <= 1'b0;
      e <= '0;
      ca <= '0;
      cb <= '0;
      y <= '0;
      flags <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        ra <= a;
        rb <= b;
      end
      if (state == MUL) begin
        p <= prod;
        sign <= sa ^ sb;
        e <= $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'(EXP_BIAS);
        ca <= cla;
        cb <= clb;
      end
`ifdef FP_MUL_ROUND_NEAREST_EN
      if (state == NORM) e <= n_e;
      if (state == RND) begin
`else
      if (state == NORM) begin
`endif
        y <= r_y;
        flags <= r_f;
      end
    end
  end
`ifdef FP_MUL_ROUND_NEAREST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant <= '0;
      guard <= 1'b0;
      sticky <= 1'b0;
    end else if (state == NORM) begin
      mant <= n_mant;
      guard <= p[47] ? p[23] : p[22];
      sticky <= p[47] ? |p[22:0] : |p[21:0];
    end
  end
`endif
  assign {flag_ovf, flag_unf, flag_inv} = flags;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// tb_fp_mul_seq_ctrl: directed vector table plus backpressure and mid-operation reset sequences
module tb_fp_mul_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, flag_ovf, flag_unf, flag_inv, busy;
  logic [31:0] y;
  int n_vec = 0, n_err = 0;
`ifdef FP_MUL_ROUND_NEAREST_EN
  localparam int LAT = 4;
  localparam logic [31:0] RND_Y = 32'h4010_0002;
`else
  localparam int LAT = 3;
  localparam logic [31:0] RND_Y = 32'h4010_0001;
`endif
  typedef struct {
    logic [31:0] a, b, y;
    logic [2:0] f;
  } vec_t;
  vec_t tbl[14];

  fp_mul_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .flag_ovf(flag_ovf),
    .flag_unf(flag_unf), .flag_inv(flag_inv), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] va, input logic [31:0] vb, output int lat);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat, seen;
    logic [31:0] hy;
    tbl[0]  = '{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000};
    tbl[1]  = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b100};
    tbl[2]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b010};
    tbl[3]  = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 3'b000};
    tbl[4]  = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b001};
    tbl[5]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000};
    tbl[6]  = '{32'h3FC0_0001, 32'h3FC0_0001, RND_Y, 3'b000};
    tbl[7]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b001};
    tbl[8]  = '{32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000};
    tbl[9]  = '{32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, 3'b000};
    tbl[10] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 3'b000};
    tbl[11] = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b100};
    tbl[12] = '{32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 3'b000};
    tbl[13] = '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b010};
    #1;
    chk("reset y", y, 32'h0);
    chk("reset ctl", {in_ready, out_valid, busy, flag_ovf, flag_unf, flag_inv}, 6'b100000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      issue(tbl[i].a, tbl[i].b, lat);
      chk($sformatf("v%0d latency", i), lat, LAT);
      chk($sformatf("v%0d y", i), y, tbl[i].y);
      chk($sformatf("v%0d flags", i), {flag_ovf, flag_unf, flag_inv}, tbl[i].f);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d back to idle", i), {in_ready, out_valid, busy}, 3'b100);
    end
    out_ready = 1'b0;
    issue(32'h3FC0_0000, 32'h4000_0000, lat);
    chk("bp latency", lat, LAT);
    hy = y;
    chk("bp y", hy, 32'h4040_0000);
    a = 32'h7F00_0000;
    b = 32'h7F00_0000;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp hold %0d", k), {y, flag_ovf, flag_unf, flag_inv, out_valid, in_ready},
          {hy, 3'b000, 2'b10});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release", {in_ready, out_valid}, 2'b10);
    a = 32'h4000_0000;
    b = 32'h4000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-reset busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid reset y", y, 32'h0);
    chk("mid reset ctl", {in_ready, out_valid, busy, flag_ovf, flag_unf, flag_inv}, 6'b100000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("no out_valid after reset", seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fp_mul_seq_ctrl.md
Name: fp_mul_seq_ctrl

Overview:
Sequencing controller for the single-precision floating-point multiplier.
- Accepts two IEEE-754 binary32 operands over a valid/ready handshake.
- Unpacks the operands and drives the existing 24x24 Booth/Wallace mantissa multiplier (mul_24bit, purely combinational).
- Registers the 48-bit product, then normalises, packs and handles special cases.
- Holds the result until the consumer accepts it, turning the combinational mantissa core into a handshaked multi-cycle unit.

Parameters:
EXP_W, 8, exponent field width
MANT_W, 23, stored fraction width (multiplier operand width = MANT_W+1)
EXP_BIAS, 127, exponent bias
QNAN, 32'h7FC00000, canonical quiet NaN returned for invalid operations

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  controller can accept operands
a  in  32  operand A, binary32
b  in  32  operand B, binary32
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y  out  32  product, binary32
flag_ovf  out  1  overflow to infinity, valid with out_valid
flag_unf  out  1  underflow flushed to zero, valid with out_valid
flag_inv  out  1  invalid operation (NaN produced), valid with out_valid
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, y=0, all flags=0, busy=0.
- FSM states: IDLE -> MUL -> NORM [-> RND] -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register a and b, go to MUL.
  - in_ready is 0 in every other state; no new operand is accepted in DONE.
- MUL (one cycle):
  - Mantissa ma = {1'b1, frac} when exp != 0; ma = 0 when exp == 0 (denormals flushed to zero).
  - Drive mul_24bit with ma and mb; register the 48-bit product P.
  - Register sign = sa ^ sb.
  - Register e = ea + eb - EXP_BIAS as a 10-bit signed value (range -127..383, no wrap).
  - Register class bits for each operand: zero, inf, nan.
- NORM:
  - If P[47]=1: mant = P[46:24], e = e+1, guard = P[23], sticky = |P[22:0].
  - Else: mant = P[45:23], guard = P[22], sticky = |P[21:0].
- RND: exists only with ROUND_NEAREST_EN (see below).
- Result selection, in priority order:
  1. Either operand NaN, or inf x zero: y=QNAN, flag_inv=1.
  2. Either operand inf: y={sign, 8'hFF, 23'h0}.
  3. Either operand zero (including flushed denormals): y={sign, 31'h0}.
  4. e >= 255: y={sign, 8'hFF, 23'h0}, flag_ovf=1.
  5. e <= 0: y={sign, 31'h0}, flag_unf=1.
  6. Otherwise: y={sign, e[7:0], mant}.
- DONE:
  - out_valid=1; y and flags are held stable while out_ready=0.
  - On out_ready, out_valid falls on the next edge and state returns to IDLE.
- Latency and throughput:
  - Accept edge to out_valid: 3 cycles (4 with rounding).
  - Minimum issue interval: 4 cycles (5 with rounding).
- Rounding: default is truncation (round toward zero).
- Reset mid-operation (any state): immediate return to reset values; the in-flight result is discarded and no out_valid pulse is produced.
- Simultaneous events: in_valid while not in IDLE is ignored, and the operands must be held by the producer. out_ready while in IDLE has no effect.

Optional Feature:
- Macro: FP_MUL_ROUND_NEAREST_EN.
- When defined:
  - NORM is followed by an RND state.
  - Round up when guard && (sticky || mant[0]) (round-to-nearest-even).
  - A mantissa carry-out sets mant=0 and e=e+1.
  - The overflow check (e >= 255) is applied after rounding.
  - Latency +1 cycle.
- When undefined: there is no RND state and the result is truncated.

Decomposition:
- Package fp_mul_pkg:
  - state enum (IDLE, MUL, NORM, RND, DONE);
  - EXP_W, MANT_W, EXP_BIAS, QNAN, POS_INF, ZERO;
  - operand-class struct {zero, inf, nan}.
- Sub-module fp_unpack: purely combinational. Splits a binary32 into sign, exponent, 24-bit mantissa with the hidden bit and denormal flush applied, and the class bits. Instantiated twice.
- mul_24bit is instantiated as-is.

Test Plan:
- 1.5 x 2.0: a=3FC00000, b=40000000, out_ready=1 -> y=40400000, no flags, out_valid exactly 3 cycles after accept.
- Overflow: a=b=7F000000 -> y=7F800000, flag_ovf=1.
- Underflow and zero: a=b=00800000 -> y=00000000, flag_unf=1; a=80000000, b=3F800000 -> y=80000000, no flags.
- Specials: a=00000000, b=7F800000 -> y=7FC00000, flag_inv=1; a=FF800000, b=40000000 -> y=FF800000.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> y, flags and out_valid stable and in_ready=0; then a new op with rst_n pulsed low in NORM -> all outputs at reset values, no out_valid.
- Rounding: a=b=3FC00001 -> y=40100001 without FP_MUL_ROUND_NEAREST_EN; y=40100002 with it, and latency 4.
